// File: rtl/fetch_stage.sv
// Instruction fetch stage: one outstanding request to instruction memory, a
// one-entry skid buffer for responses that arrive while decode is stalled,
// branch redirection with discard of stale responses, and a halt opcode that
// stops fetching until the next branch or reset.
module fetch_stage #(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter logic [3:0]  HALT_OP  = 4'hF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [15:0] branch_target,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic        imem_valid,
    input  logic [15:0] imem_rdata,
    output logic [15:0] if_instr,
    output logic [15:0] if_pc_plus2,
    output logic        if_valid,
    output logic        halted
);

    typedef enum logic [1:0] {
        StWait  = 2'd0,
        StSkid  = 2'd1,
        StDrain = 2'd2,
        StHalt  = 2'd3
    } state_e;

    state_e      state_q, state_d;
    logic [15:0] pc_q, pc_d;
    // Address of the stale request still in flight while draining.
    logic [15:0] drain_addr_q, drain_addr_d;
    logic [15:0] instr_q, instr_d;
    logic [15:0] pcp2_q, pcp2_d;
    logic        valid_q, valid_d;
    logic [15:0] skid_instr_q, skid_instr_d;
    logic [15:0] skid_pcp2_q, skid_pcp2_d;

    logic [15:0] pc_plus2;
    logic [15:0] target_even;
    logic        req_active;
    logic        rdata_is_halt;
    logic        skid_is_halt;

    assign pc_plus2      = pc_q + 16'd2;
    assign target_even   = branch_target & 16'hFFFE;
    assign req_active    = (state_q == StWait) || (state_q == StDrain);
    assign rdata_is_halt = (imem_rdata[15:12] == HALT_OP);
    assign skid_is_halt  = (skid_instr_q[15:12] == HALT_OP);

    // Request and pipeline-register outputs; reset masks the request immediately.
    always_comb begin
        imem_req    = req_active && !rst;
        imem_addr   = (state_q == StDrain) ? drain_addr_q : pc_q;
        if_instr    = instr_q;
        if_pc_plus2 = pcp2_q;
        if_valid    = valid_q;
        halted      = (state_q == StHalt) && !rst;
    end

    // Next-state: branch wins over stall and capture; otherwise per-state fetch flow.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        drain_addr_d = drain_addr_q;
        instr_d      = instr_q;
        pcp2_d       = pcp2_q;
        valid_d      = stall ? valid_q : 1'b0;
        skid_instr_d = skid_instr_q;
        skid_pcp2_d  = skid_pcp2_q;

        if (branch_taken) begin
            pc_d         = target_even;
            valid_d      = 1'b0;
            skid_instr_d = 16'h0000;
            skid_pcp2_d  = 16'h0000;
            if (req_active && !imem_valid) begin
                // A response is still coming back for the old path; drop it first.
                state_d = StDrain;
                if (state_q == StWait) begin
                    drain_addr_d = pc_q;
                end
            end else begin
                state_d = StWait;
            end
        end else begin
            case (state_q)
                StWait: begin
                    if (imem_valid) begin
                        pc_d = pc_plus2;
                        if (stall) begin
                            skid_instr_d = imem_rdata;
                            skid_pcp2_d  = pc_plus2;
                            state_d      = StSkid;
                        end else begin
                            instr_d = imem_rdata;
                            pcp2_d  = pc_plus2;
                            valid_d = 1'b1;
                            state_d = rdata_is_halt ? StHalt : StWait;
                        end
                    end
                end
                StSkid: begin
                    if (!stall) begin
                        instr_d = skid_instr_q;
                        pcp2_d  = skid_pcp2_q;
                        valid_d = 1'b1;
                        state_d = skid_is_halt ? StHalt : StWait;
                    end
                end
                StDrain: begin
                    if (imem_valid) begin
                        state_d = StWait;
                    end
                end
                StHalt: begin
                    state_d = StHalt;
                end
                default: begin
                    state_d = StWait;
                end
            endcase
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StWait;
            pc_q         <= RESET_PC;
            drain_addr_q <= 16'h0000;
            instr_q      <= 16'h0000;
            pcp2_q       <= 16'h0000;
            valid_q      <= 1'b0;
            skid_instr_q <= 16'h0000;
            skid_pcp2_q  <= 16'h0000;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            drain_addr_q <= drain_addr_d;
            instr_q      <= instr_d;
            pcp2_q       <= pcp2_d;
            valid_q      <= valid_d;
            skid_instr_q <= skid_instr_d;
            skid_pcp2_q  <= skid_pcp2_d;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: memory with configurable latency, a queue-based
// reference model compared every cycle, directed scenarios with literal
// expectations, then randomized stall/branch/reset traffic.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        branch_taken = 1'b0;
    logic [15:0] branch_target = 16'h0000;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_valid = 1'b0;
    logic [15:0] imem_rdata = 16'h0000;
    logic [15:0] if_instr;
    logic [15:0] if_pc_plus2;
    logic        if_valid;
    logic        halted;

    always #5 clk = ~clk;

    fetch_stage dut (
        .clk          (clk),
        .rst          (rst),
        .stall        (stall),
        .branch_taken (branch_taken),
        .branch_target(branch_target),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_valid   (imem_valid),
        .imem_rdata   (imem_rdata),
        .if_instr     (if_instr),
        .if_pc_plus2  (if_pc_plus2),
        .if_valid     (if_valid),
        .halted       (halted)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Memory
    logic [15:0] mem [65536];
    bit          m_busy = 0;
    int          m_rem  = 0;
    logic [15:0] m_addr = 16'h0000;
    int          lat    = 1;

    // Reference model
    logic [15:0] r_pc, r_stale, r_instr, r_pcp2;
    bit          r_ifv, r_halt, r_fetch, r_drop;
    logic [31:0] r_skid [$];
    bit          cur_rst = 1;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic timeout(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: timed out waiting (t=%0t)", name, $time);
    endtask

    task automatic model_update(input bit rv, input bit sv, input bit bv, input logic [15:0] tv,
                                input bit vv, input logic [15:0] dv);
        bit          got;
        logic [15:0] ci, cp;
        got = 0;
        ci = 16'h0000;
        cp = 16'h0000;
        if (rv) begin
            r_pc = 16'h0000; r_instr = 16'h0000; r_pcp2 = 16'h0000;
            r_ifv = 0; r_halt = 0; r_fetch = 1; r_drop = 0;
            r_skid.delete();
        end else if (bv) begin
            if (r_fetch && !vv) begin
                if (!r_drop) r_stale = r_pc;
                r_drop = 1;
            end else begin
                r_drop = 0;
            end
            r_pc = tv & 16'hFFFE;
            r_fetch = 1; r_halt = 0; r_ifv = 0;
            r_skid.delete();
        end else begin
            if (r_fetch && vv) begin
                if (r_drop) begin
                    r_drop = 0;
                end else begin
                    if (sv) begin
                        r_skid.push_back({dv, r_pc + 16'd2});
                        r_fetch = 0;
                    end else begin
                        got = 1; ci = dv; cp = r_pc + 16'd2;
                    end
                    r_pc = r_pc + 16'd2;
                end
            end else if (r_skid.size() > 0 && !sv) begin
                {ci, cp} = r_skid.pop_front();
                got = 1;
                r_fetch = 1;
            end
            if (got) begin
                r_instr = ci; r_pcp2 = cp; r_ifv = 1;
                if (ci[15:12] == 4'hF) begin
                    r_halt = 1;
                    r_fetch = 0;
                end
            end else if (!sv) begin
                r_ifv = 0;
            end
        end
    endtask

    task automatic compare_model();
        bit exp_req;
        exp_req = r_fetch && !cur_rst;
        check("m_req", imem_req, exp_req);
        if (exp_req) check("m_addr", imem_addr, r_drop ? r_stale : r_pc);
        check("m_if_valid", if_valid, r_ifv);
        check("m_if_instr", if_instr, r_instr);
        check("m_if_pc_plus2", if_pc_plus2, r_pcp2);
        check("m_halted", halted, r_halt && !cur_rst);
    endtask

    // One clock: drive inputs at the negedge, advance memory and model, compare at next negedge.
    task automatic do_cycle(input bit rv, input bit sv, input bit bv, input logic [15:0] tv);
        rst = rv; stall = sv; branch_taken = bv; branch_target = tv;
        if (!rv && m_busy && m_rem == 1) begin
            imem_valid = 1'b1;
            imem_rdata = mem[m_addr];
        end else begin
            imem_valid = 1'b0;
            imem_rdata = 16'($urandom);
        end
        #1;
        if (rv) begin
            m_busy = 0;
        end else if (m_busy) begin
            if (imem_req) check("addr_stable", imem_addr, m_addr);
            m_rem--;
            if (m_rem == 0) m_busy = 0;
        end else if (imem_req) begin
            m_busy = 1; m_rem = lat; m_addr = imem_addr;
        end
        model_update(rv, sv, bv, tv, imem_valid, imem_rdata);
        cur_rst = rv;
        @(negedge clk);
        compare_model();
    endtask

    task automatic run_until(input logic [15:0] a, input int rem, input string name);
        bit ok;
        ok = 0;
        for (int i = 0; i < 40 && !ok; i++) begin
            do_cycle(0, 0, 0, 16'h0000);
            ok = m_busy && (m_addr == a) && (m_rem == rem);
        end
        if (!ok) timeout(name);
    endtask

    initial begin
        logic [15:0] w;
        bit          ok;
        for (int i = 0; i < 65536; i++) begin
            w = 16'($urandom);
            if (w[15:12] == 4'hF && $urandom_range(3) != 0) w[15:12] = 4'h7;
            mem[i] = w;
        end
        mem[16'h0000] = 16'h1234; mem[16'h0002] = 16'h1111;
        mem[16'h0004] = 16'hABCD; mem[16'h0006] = 16'h2222;
        mem[16'h0010] = 16'h1000; mem[16'hFF08] = 16'h3333;
        mem[16'hFF0A] = 16'h4444; mem[16'h0020] = 16'hF000;
        mem[16'h0040] = 16'h1000; mem[16'h0100] = 16'h5555;
        mem[16'hFFFE] = 16'h0001;

        @(negedge clk);
        // Reset and first fetch with a 1-cycle memory
        lat = 1;
        do_cycle(1, 0, 0, 16'h0000);
        do_cycle(1, 0, 0, 16'h0000);
        check("rst_req", imem_req, 1'b0);
        check("rst_if_valid", if_valid, 1'b0);
        check("rst_if_instr", if_instr, 16'h0000);
        check("rst_if_pc_plus2", if_pc_plus2, 16'h0000);
        check("rst_halted", halted, 1'b0);
        do_cycle(0, 0, 0, 16'h0000);
        check("first_req", imem_req, 1'b1);
        check("first_addr", imem_addr, 16'h0000);
        do_cycle(0, 0, 0, 16'h0000);
        check("first_instr", if_instr, 16'h1234);
        check("first_pcp2", if_pc_plus2, 16'h0002);
        check("first_valid", if_valid, 1'b1);
        check("next_addr", imem_addr, 16'h0002);

        // Response arrives while stalled
        run_until(16'h0004, 1, "reach_0004");
        do_cycle(0, 1, 0, 16'h0000);
        check("stall_instr_hold", if_instr, 16'h1111);
        check("stall_pcp2_hold", if_pc_plus2, 16'h0004);
        check("stall_req_low", imem_req, 1'b0);
        do_cycle(0, 1, 0, 16'h0000);
        check("stall2_req_low", imem_req, 1'b0);
        check("stall2_valid_hold", if_valid, 1'b0);
        do_cycle(0, 0, 0, 16'h0000);
        check("skid_instr", if_instr, 16'hABCD);
        check("skid_pcp2", if_pc_plus2, 16'h0006);
        check("skid_valid", if_valid, 1'b1);
        check("skid_next_addr", imem_addr, 16'h0006);

        // Branch with a 3-cycle request outstanding
        lat = 3;
        do_cycle(1, 0, 0, 16'h0000);
        do_cycle(1, 0, 0, 16'h0000);
        do_cycle(0, 0, 1, 16'h0010);
        run_until(16'h0010, 3, "reach_0010");
        do_cycle(0, 0, 1, 16'hFF08);
        check("drain_addr_held", imem_addr, 16'h0010);
        check("drain_valid0", if_valid, 1'b0);
        do_cycle(0, 0, 0, 16'h0000);
        check("drain_addr_held2", imem_addr, 16'h0010);
        check("drain_valid1", if_valid, 1'b0);
        do_cycle(0, 0, 0, 16'h0000);
        check("redirect_addr", imem_addr, 16'hFF08);
        check("redirect_req", imem_req, 1'b1);
        check("redirect_valid", if_valid, 1'b0);
        for (int i = 0; i < 4; i++) do_cycle(0, 0, 0, 16'h0000);
        check("redirect_instr", if_instr, 16'h3333);
        check("redirect_pcp2", if_pc_plus2, 16'hFF0A);

        // Halt opcode
        lat = 1;
        do_cycle(0, 0, 1, 16'h0020);
        ok = 0;
        for (int i = 0; i < 10 && !ok; i++) begin
            do_cycle(0, 0, 0, 16'h0000);
            ok = halted;
        end
        if (!ok) timeout("reach_halt");
        check("halt_instr", if_instr, 16'hF000);
        check("halt_pcp2", if_pc_plus2, 16'h0022);
        for (int i = 0; i < 10; i++) begin
            do_cycle(0, (i % 3) == 0, 0, 16'h0000);
            check("halt_held", halted, 1'b1);
            check("halt_req_low", imem_req, 1'b0);
        end
        do_cycle(0, 0, 1, 16'h0040);
        check("unhalt", halted, 1'b0);
        check("unhalt_req", imem_req, 1'b1);
        check("unhalt_addr", imem_addr, 16'h0040);

        // Branch + stall + response in the same cycle
        run_until(16'h0040, 1, "reach_0040");
        do_cycle(0, 1, 1, 16'h0100);
        check("bsv_valid", if_valid, 1'b0);
        check("bsv_req", imem_req, 1'b1);
        check("bsv_addr", imem_addr, 16'h0100);

        // PC wrap, odd target forced even
        do_cycle(0, 0, 1, 16'hFFFF);
        ok = 0;
        for (int i = 0; i < 10 && !ok; i++) begin
            do_cycle(0, 0, 0, 16'h0000);
            ok = if_valid;
        end
        if (!ok) timeout("reach_wrap");
        check("wrap_instr", if_instr, 16'h0001);
        check("wrap_pcp2", if_pc_plus2, 16'h0000);
        check("wrap_addr", imem_addr, 16'h0000);

        // Randomized traffic
        for (int i = 0; i < 4000; i++) begin
            bit          rv, sv, bv;
            logic [15:0] tv;
            rv = ($urandom_range(199) == 0);
            if (rv) lat = $urandom_range(4, 1);
            sv = ($urandom_range(99) < 30);
            bv = ($urandom_range(99) < 6);
            tv = 16'($urandom);
            if ($urandom_range(7) == 0) tv = 16'hFFF0 | 16'($urandom_range(15));
            do_cycle(rv, sv, bv, tv);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
